// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready port shared by the fetch stage and the memory.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, writes IF/ID with a one-entry
// skid for stalls, applies ID redirects and stops on the halt opcode.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [15:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic                   if_id_wen,
  output logic                   if_id_flush,
  output logic [15:0]            if_id_pcplus2,
  output logic [15:0]            if_id_instr,
  output logic                   halted
);
  typedef enum logic [1:0] {FETCH, DISCARD, HALTED} fsm_t;

  fsm_t        fsm;
  logic [15:0] pc;
  logic [15:0] disc_addr;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc2;
  logic [15:0] pc_plus2;
  logic        pend;
  logic        skid_v;
  logic        req;
  logic        accept;
  logic        deliver;

  assign pc_plus2 = pc + 16'd2;

  always_comb begin
    req = 1'b0;
    case (fsm)
      FETCH:   req = pend | (~stall & ~skid_v);
      DISCARD: req = 1'b1;
      default: req = pend;
    endcase
    req = req & rst_n;
  end

  // DISCARD keeps the abandoned request's address on the bus until it completes.
  assign imem.imem_req  = req;
  assign imem.imem_addr = (fsm == DISCARD) ? disc_addr : pc;

  assign accept  = req & imem.imem_ready & ~redirect & (fsm == FETCH);
  assign deliver = skid_v & ~stall & ~redirect;

  always_comb begin
    if_id_wen     = 1'b0;
    if_id_instr   = '0;
    if_id_pcplus2 = '0;
    if (deliver) begin
      if_id_wen     = 1'b1;
      if_id_instr   = skid_instr;
      if_id_pcplus2 = skid_pc2;
    end else if (accept & ~stall) begin
      if_id_wen     = 1'b1;
      if_id_instr   = imem.imem_rdata;
      if_id_pcplus2 = pc_plus2;
    end
  end

  assign if_id_flush = redirect & rst_n;
  assign halted      = (fsm == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      fsm        <= FETCH;
      pend       <= 1'b0;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_pc2   <= '0;
      disc_addr  <= '0;
    end else if (redirect) begin
      // An unfinished request must still be drained; one completing now is just dropped.
      pc        <= redirect_pc;
      skid_v    <= 1'b0;
      disc_addr <= imem.imem_addr;
      pend      <= pend & ~imem.imem_ready;
      fsm       <= (pend & ~imem.imem_ready) ? DISCARD : FETCH;
    end else begin
      pend <= req & ~imem.imem_ready;
      if (deliver)
        skid_v <= 1'b0;
      case (fsm)
        FETCH: begin
          if (accept) begin
            pc <= pc_plus2;
            if (stall) begin
              skid_v     <= 1'b1;
              skid_instr <= imem.imem_rdata;
              skid_pc2   <= pc_plus2;
            end
            if (imem.imem_rdata[15:12] == HLT_OPCODE)
              fsm <= HALTED;
          end
        end
        DISCARD: begin
          if (imem.imem_ready)
            fsm <= FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected IF/ID writes are queued by each
// scenario and checked by a monitor whenever if_id_wen fires.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_id_wen;
  logic        if_id_flush;
  logic [15:0] if_id_pcplus2;
  logic [15:0] if_id_instr;
  logic        halted;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem), .if_id_wen(if_id_wen),
    .if_id_flush(if_id_flush), .if_id_pcplus2(if_id_pcplus2),
    .if_id_instr(if_id_instr), .halted(halted)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int unsigned lat = 0;

  // Memory: ready once a request has waited lat cycles at a stable address.
  logic [15:0] prev_addr;
  logic        prev_wait;
  int unsigned wait_cnt;
  int unsigned cur_wait;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0020: return 16'h1234;
      16'h0030: return 16'hF000;
      default:  return a ^ 16'hA000;
    endcase
  endfunction

  always_comb begin
    cur_wait        = (prev_wait && imem.imem_addr == prev_addr) ? wait_cnt : 0;
    imem.imem_ready = imem.imem_req && (cur_wait >= lat);
    imem.imem_rdata = imem.imem_ready ? mem_word(imem.imem_addr) : 16'hDEAD;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_addr <= '0;
      prev_wait <= 1'b0;
      wait_cnt  <= 0;
    end else begin
      prev_addr <= imem.imem_addr;
      prev_wait <= imem.imem_req && !imem.imem_ready;
      wait_cnt  <= cur_wait + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_id_wen === 1'b1) begin
      logic [31:0] exp;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wen_unexpected: got pcplus2=%h instr=%h, want no write", if_id_pcplus2, if_id_instr);
      end else begin
        exp = exp_q.pop_front();
        if ({if_id_pcplus2, if_id_instr} !== exp) begin
          bad++;
          $display("FAIL ifid_data: got pcplus2=%h instr=%h, want pcplus2=%h instr=%h",
                   if_id_pcplus2, if_id_instr, exp[31:16], exp[15:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [15:0] a);
    redirect = 1'b1; redirect_pc = a; stall = 1'b1;
    next_cycle();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem.imem_req); end
    total++; if (imem.imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h want 0000", imem.imem_addr); end
    total++; if ({if_id_wen, if_id_flush, halted} !== 3'b000) begin bad++; $display("FAIL rst_ctl: got %b want 000", {if_id_wen, if_id_flush, halted}); end
    total++; if ({if_id_pcplus2, if_id_instr} !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {if_id_pcplus2, if_id_instr}); end
    next_cycle();
  endtask

  task automatic test_zero_wait();
    lat = 0;
    exp_q.push_back({16'h0002, 16'hA000});
    exp_q.push_back({16'h0004, 16'hA002});
    exp_q.push_back({16'h0006, 16'hA004});
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'(2 * i)) begin bad++; $display("FAIL zw_req: got req=%b addr=%h want req=1 addr=%h", imem.imem_req, imem.imem_addr, 16'(2 * i)); end
      total++; if (if_id_wen !== 1'b1) begin bad++; $display("FAIL zw_wen: got %b want 1", if_id_wen); end
      next_cycle();
    end
    stall = 1'b1;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL zw_stop: got req=%b want 0", imem.imem_req); end
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zw_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wait3();
    jump(16'h0010);
    lat = 2; stall = 1'b0;
    exp_q.push_back({16'h0012, 16'hA010});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0010) begin bad++; $display("FAIL w3_req: got req=%b addr=%h want req=1 addr=0010", imem.imem_req, imem.imem_addr); end
      total++; if (if_id_wen !== (i == 2)) begin bad++; $display("FAIL w3_wen: cycle %0d got %b want %b", i, if_id_wen, (i == 2)); end
      next_cycle();
    end
    stall = 1'b1;
    @(negedge clk);
    total++; if (imem.imem_addr !== 16'h0012) begin bad++; $display("FAIL w3_pc: got %h want 0012", imem.imem_addr); end
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL w3_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall_skid();
    jump(16'h0020);
    lat = 1; stall = 1'b0;
    exp_q.push_back({16'h0022, 16'h1234});
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0020) begin bad++; $display("FAIL sk_issue: got req=%b addr=%h want req=1 addr=0020", imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || if_id_wen !== 1'b0) begin bad++; $display("FAIL sk_ready: got req=%b wen=%b want req=1 wen=0", imem.imem_req, if_id_wen); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (imem.imem_req !== 1'b0 || if_id_wen !== 1'b0) begin bad++; $display("FAIL sk_hold: got req=%b wen=%b want req=0 wen=0", imem.imem_req, if_id_wen); end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if (if_id_wen !== 1'b1 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL sk_deliver: got wen=%b req=%b want wen=1 req=0", if_id_wen, imem.imem_req); end
    next_cycle();
    lat = 0;
    exp_q.push_back({16'h0024, 16'hA022});
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0022) begin bad++; $display("FAIL sk_next: got req=%b addr=%h want req=1 addr=0022", imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sk_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_discard();
    jump(16'h0008);
    lat = 2; stall = 1'b0;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0008) begin bad++; $display("FAIL rd_issue: got req=%b addr=%h want req=1 addr=0008", imem.imem_req, imem.imem_addr); end
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1;
    @(negedge clk);
    total++; if (if_id_flush !== 1'b1 || if_id_wen !== 1'b0) begin bad++; $display("FAIL rd_flush: got flush=%b wen=%b want flush=1 wen=0", if_id_flush, if_id_wen); end
    next_cycle();
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0008 || imem.imem_ready !== 1'b1) begin bad++; $display("FAIL rd_drain: got req=%b addr=%h rdy=%b want req=1 addr=0008 rdy=1", imem.imem_req, imem.imem_addr, imem.imem_ready); end
    total++; if (if_id_wen !== 1'b0) begin bad++; $display("FAIL rd_drop: got wen=%b want 0", if_id_wen); end
    next_cycle();
    lat = 0;
    exp_q.push_back({16'h0102, 16'hA100});
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0100) begin bad++; $display("FAIL rd_target: got req=%b addr=%h want req=1 addr=0100", imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rd_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_halt();
    jump(16'h0030);
    lat = 0; stall = 1'b0;
    exp_q.push_back({16'h0032, 16'hF000});
    @(negedge clk);
    total++; if (if_id_wen !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL ht_fetch: got wen=%b halted=%b want wen=1 halted=0", if_id_wen, halted); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (halted !== 1'b1 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL ht_stop: got halted=%b req=%b want halted=1 req=0", halted, imem.imem_req); end
      next_cycle();
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    total++; if (if_id_flush !== 1'b1 || if_id_wen !== 1'b0) begin bad++; $display("FAIL ht_flush: got flush=%b wen=%b want flush=1 wen=0", if_id_flush, if_id_wen); end
    next_cycle();
    redirect = 1'b0;
    exp_q.push_back({16'h0042, 16'hA040});
    @(negedge clk);
    total++; if (halted !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0040) begin bad++; $display("FAIL ht_resume: got halted=%b req=%b addr=%h want halted=0 req=1 addr=0040", halted, imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ht_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    jump(16'hFFFE);
    lat = 0; stall = 1'b0;
    exp_q.push_back({16'h0000, 16'h5FFE});
    exp_q.push_back({16'h0002, 16'hA000});
    @(negedge clk);
    total++; if (imem.imem_addr !== 16'hFFFE) begin bad++; $display("FAIL wr_addr: got %h want FFFE", imem.imem_addr); end
    next_cycle();
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000) begin bad++; $display("FAIL wr_next: got req=%b addr=%h want req=1 addr=0000", imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    jump(16'h0050);
    lat = 3; stall = 1'b0;
    next_cycle();
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0050) begin bad++; $display("FAIL rm_pend: got req=%b addr=%h want req=1 addr=0050", imem.imem_req, imem.imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 16'h0000 || if_id_wen !== 1'b0) begin bad++; $display("FAIL rm_reset: got req=%b addr=%h wen=%b want req=0 addr=0000 wen=0", imem.imem_req, imem.imem_addr, if_id_wen); end
    next_cycle();
    lat = 0;
    exp_q.push_back({16'h0002, 16'hA000});
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0000) begin bad++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=0000", imem.imem_req, imem.imem_addr); end
    next_cycle();
    stall = 1'b1;
    next_cycle();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rm_left: got %0d queued want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_zero_wait();
    test_wait3();
    test_stall_skid();
    test_redirect_discard();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want finish before 100000");
    $fatal(1);
  end
endmodule
